// File: rtl/tick_pkg.sv
// Shared constants for the tick/BCD counter slice: FSM state encoding and BCD digit width.
package tick_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int BCD_W = 4;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for a tick stream; TICK_SYNC_EN adds a two-flop synchronizer in front.
// All flops reset high so a level that is already high at reset release is not seen as an edge.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic rise
);

  logic tick_s;
  logic tick_q;

`ifdef TICK_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= tick_in;
      sync2 <= sync1;
    end
  end

  assign tick_s = sync2;
`else
  assign tick_s = tick_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_s;
    end
  end

  assign rise = tick_s & ~tick_q;

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD tick counter, modulo MODULO, with IDLE/RUN/HOLD control and a wrap pulse.
// Optional input synchronizer is selected with the TICK_SYNC_EN macro (see tick_edge_detect).
module tick_bcd_counter
  import tick_pkg::*;
#(
  parameter int MODULO = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic             wrap,
  output logic             running,
  output logic [1:0]       state
);

  localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'((MODULO - 1) / 10);
  localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'((MODULO - 1) % 10);
  localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

  logic       tick_rise;
  logic [1:0] state_nxt;
  logic       count_en;
  logic       at_max;

  tick_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .rise    (tick_rise)
  );

  // Control wins over counting: a tick in a cycle that changes state is dropped.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else if (stop && (state == ST_RUN)) begin
      state_nxt = ST_HOLD;
    end else if (start && ((state == ST_IDLE) || (state == ST_HOLD))) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      count_en = tick_rise;
    end
  end

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ones    <= '0;
      tens    <= '0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      wrap    <= count_en && at_max;
      if (clr) begin
        ones <= '0;
        tens <= '0;
      end else if (count_en) begin
        if (at_max) begin
          ones <= '0;
          tens <= '0;
        end else if (ones == NINE) begin
          ones <= '0;
          tens <= tens + 1'b1;
        end else begin
          ones <= ones + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed plus random bench for tick_bcd_counter against an integer-count reference model.
// Define TICK_SYNC_EN for both bench and RTL to exercise the synchronized build.
module tb_tick_bcd_counter;

  localparam int MODULO = 60;
`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       wrap;
  logic       running;
  logic [1:0] state;

  int tests;
  int failed;
  int wrap_seen;

  // reference model: count as a plain integer, digits derived by / and %
  int m_count;
  int m_mode;
  bit m_wrap;
  bit m_prev;
`ifdef TICK_SYNC_EN
  bit m_hist[$];
`endif

  tick_bcd_counter #(.MODULO(MODULO)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .ones    (ones),
    .tens    (tens),
    .wrap    (wrap),
    .running (running),
    .state   (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit t_eff;
    bit rise;
`ifdef TICK_SYNC_EN
    t_eff = m_hist.pop_front();
    m_hist.push_back(tick_in);
`else
    t_eff = tick_in;
`endif
    rise   = t_eff && !m_prev;
    m_prev = t_eff;
    m_wrap = 1'b0;
    if (!rst) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_prev  = 1'b1;
`ifdef TICK_SYNC_EN
      m_hist = {1'b1, 1'b1};
`endif
    end else if (clr) begin
      m_mode  = M_IDLE;
      m_count = 0;
    end else if (stop && m_mode == M_RUN) begin
      m_mode = M_HOLD;
    end else if (start && m_mode != M_RUN) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && rise) begin
      if (m_count == MODULO - 1) begin
        m_count = 0;
        m_wrap  = 1'b1;
      end else begin
        m_count++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (wrap) wrap_seen++;
    chk("ones", 8'(ones), 8'(m_count % 10));
    chk("tens", 8'(tens), 8'(m_count / 10));
    chk("wrap", 8'(wrap), 8'(m_wrap));
    chk("running", 8'(running), 8'(m_mode == M_RUN));
    chk("state", 8'(state), 8'(m_mode));
  endtask

  task automatic tick_edge();
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
  endtask

  task automatic flush();
    repeat (3) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    logic [3:0] v0;
    tests = 0;
    failed = 0;
    wrap_seen = 0;
    m_count = 0;
    m_mode = M_IDLE;
    m_wrap = 1'b0;
    m_prev = 1'b1;
`ifdef TICK_SYNC_EN
    m_hist = {1'b1, 1'b1};
`endif
    rst = 1'b0; tick_in = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;

    // reset with tick_in high, then release: no phantom tick
    repeat (3) cyc();
    chk("rst_ones", 8'(ones), 8'd0);
    chk("rst_running", 8'(running), 8'd0);
    rst = 1'b1;
    repeat (3) cyc();
    pulse_start();
    chk("start_running", 8'(running), 8'd1);
    flush();
    chk("noedge_ones", 8'(ones), 8'd0);
    chk("noedge_tens", 8'(tens), 8'd0);

    // 12 edges
    wrap_seen = 0;
    repeat (12) tick_edge();
    flush();
    chk("t12_tens", 8'(tens), 8'd1);
    chk("t12_ones", 8'(ones), 8'd2);
    chk("t12_nowrap", 8'(wrap_seen), 8'd0);

    // full wrap
    do_clr();
    pulse_start();
    wrap_seen = 0;
    repeat (MODULO - 1) tick_edge();
    flush();
    chk("pre_wrap_tens", 8'(tens), 8'd5);
    chk("pre_wrap_ones", 8'(ones), 8'd9);
    tick_edge();
    flush();
    chk("wrap_count", 8'(tens * 10 + ones), 8'd0);
    chk("wrap_once", 8'(wrap_seen), 8'd1);

    // hold at 3/4
    do_clr();
    pulse_start();
    repeat (34) tick_edge();
    flush();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    repeat (5) tick_edge();
    flush();
    chk("hold_tens", 8'(tens), 8'd3);
    chk("hold_ones", 8'(ones), 8'd4);
    pulse_start();
    tick_edge();
    flush();
    chk("resume_ones", 8'(ones), 8'd5);

    // tick latency from tick_in rise to digit update
    tick_in = 1'b0;
    cyc();
    v0 = ones;
    tick_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      if (i < LAT) chk("lat_hold", 8'(ones), 8'(v0));
      else chk("lat_update", 8'(ones), 8'(v0 + 4'd1));
    end
    flush();

    // clr + start + tick in one cycle
    tick_in = 1'b0;
    cyc();
    clr = 1'b1; start = 1'b1; tick_in = 1'b1;
    cyc();
    clr = 1'b0; start = 1'b0;
    flush();
    chk("ccs_state", 8'(state), 8'(M_IDLE));
    chk("ccs_running", 8'(running), 8'd0);
    chk("ccs_count", 8'(tens * 10 + ones), 8'd0);

    // reset mid-run at 4/7
    pulse_start();
    repeat (47) tick_edge();
    flush();
    chk("r47_count", 8'(tens * 10 + ones), 8'd47);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("r47_after", 8'(tens * 10 + ones), 8'd0);
    chk("r47_running", 8'(running), 8'd0);
    chk("r47_wrap", 8'(wrap), 8'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      clr     = ($urandom_range(0, 99) == 0);
      rst     = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
# tick_bcd_counter

Two-digit BCD event counter that sits directly downstream of the frequency divider. It consumes the divider's square-wave output, detects each rising edge as one tick, and counts ticks modulo a parameterised limit under start/stop/clear control. Outputs drive the seven-segment display stage and a one-cycle wrap pulse for cascading a further counter stage.

## Interface
- MODULO, default 60: count limit. Legal range 2..100. Count runs 0..MODULO-1.
- clk  input  1  system clock; same clock that drives the frequency divider.
- rst  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- tick_in  input  1  divider output (square wave); each rising edge is one tick.
- start  input  1  level-sampled; enters RUN.
- stop  input  1  level-sampled; enters HOLD.
- clr  input  1  level-sampled; zeroes both digits and returns to IDLE.
- ones  output  4  BCD units digit, 0..9.
- tens  output  4  BCD tens digit, 0..(MODULO-1)/10.
- wrap  output  1  one-cycle pulse when the count rolls from MODULO-1 to 0.
- running  output  1  high while in RUN.

## Operation
- Edge detect:
  - tick_q registers tick_in.
  - tick_rise = tick_in & ~tick_q.
  - tick_q resets to 1, so a tick_in that is already high at reset release does not produce a tick.
- FSM states: IDLE (count = 0, ticks ignored), RUN (ticks counted), HOLD (count frozen, ticks ignored).
- Transitions, evaluated in priority order each cycle:
  - clr → IDLE from any state; count cleared.
  - stop, when in RUN → HOLD.
  - start, when in IDLE or HOLD → RUN.
  - Otherwise the state holds.
- Same-cycle input combinations: clr beats stop and start; stop beats start.
- Counting in RUN on tick_rise:
  - ones increments.
  - When ones = 9: ones → 0 and tens increments.
  - When the count equals MODULO-1: ones and tens both → 0, and wrap = 1 in the following cycle.
- A tick_rise in the same cycle as a clr is discarded.
- A tick_rise in the cycle that moves the FSM from RUN to HOLD is discarded.
- A tick_rise in the cycle that moves the FSM into RUN is not counted (the state is registered first).
- Arithmetic:
  - Digits are 4-bit BCD and never hold 10..15.
  - The wrap comparison uses the tens/ones decomposition of MODULO-1, computed at elaboration.

## Timing
- Reset values: ones = 0, tens = 0, wrap = 0, running = 0, state IDLE, tick_q = 1.
- Tick latency:
  - tick_in first sampled high at edge n.
  - Counter value updated at edge n; visible after edge n (one register stage).
- wrap: registered; high for exactly one cycle, coincident with the 0/0 count.
- running: registered decode of the state; goes high the cycle after start is sampled.
- Control inputs:
  - Synchronous to clk; no handshake.
  - Pulses of one cycle or longer are accepted.
  - A held start in RUN has no further effect.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of the FSM state or pending ticks.
- Minimum tick spacing: tick_in low for at least 1 clk cycle between edges. The divider always satisfies this.

## Configuration
- TICK_SYNC_EN:
  - Defined: tick_in passes through a two-flop synchronizer before the edge detector. Both synchronizer flops reset to 1. Tick latency becomes 3 cycles. This is for use when tick_in comes from an asynchronous source such as a button or external oscillator.
  - Undefined: no synchronizer; tick_in must be synchronous to clk; latency is 1 cycle as above.

## Structure
- Shared package tick_pkg holds:
  - State encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2.
  - BCD digit width constant BCD_W = 4.
- One sub-module, tick_edge_detect:
  - Contains the optional synchronizer plus the tick_q register.
  - Outputs the single-cycle rise pulse.
  - Reusable by the display-refresh and debounce stages.
- The FSM and the digit counters live in the top module.

## Test plan
- Reset release with tick_in = 1, then start and no edges → ones/tens stay 0, running = 1 one cycle after start.
- start, then 12 tick_in rising edges → tens = 1, ones = 2, wrap never asserted.
- MODULO = 60, RUN, 60 edges → count 5/9 after 59 edges; after the 60th edge count is 0/0 and wrap is high for exactly 1 cycle.
- At count 3/4: stop, 5 edges, then start, 1 edge → 3/4 held during HOLD, then 3/5.
- clr, start and a tick_rise all in the same cycle → state IDLE, count 0/0, running = 0.
- rst driven low for 1 cycle at count 4/7 in RUN → next cycle 0/0, running = 0, wrap = 0. Repeat the bench with TICK_SYNC_EN defined and check the update occurs 3 cycles after tick_in rises.
